// File: rtl/interval_timer_arbiter.sv
// interval_timer_arbiter
//
// Shares one WIDTH-bit interval counter between two requesters. A requester
// raises its req and presents a length; when the counter is free the block
// grants it (round-robin on ties), latches the length, counts 0..len, then
// pulses the owner's done for one cycle and returns to IDLE. Dropping the
// owner's req while the counter runs aborts the interval without a done.
//
// Ports:
//   clk            rising-edge clock
//   reset          synchronous, active-high reset
//   req0 / req1    interval requests, held until done or abort
//   len0 / len1    interval lengths, sampled only at the grant edge
//   gnt0 / gnt1    registered ownership flags (never both high)
//   done0 / done1  registered one-cycle completion pulses
//   count          registered counter value
//   busy           registered, high whenever the block is not IDLE

module interval_timer_arbiter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0,
   input  logic [WIDTH-1:0] len0,
   input  logic             req1,
   input  logic [WIDTH-1:0] len1,
   output logic             gnt0,
   output logic             gnt1,
   output logic             done0,
   output logic             done1,
   output logic [WIDTH-1:0] count,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] len_q, len_d;
   logic             last_q, last_d;
   logic             owner_q, owner_d;
   logic             gnt0_q, gnt0_d;
   logic             gnt1_q, gnt1_d;
   logic             done0_q, done0_d;
   logic             done1_q, done1_d;
   logic             busy_q, busy_d;

   logic             owner_req;
   logic             winner;

   // The owner's request decides between continuing and aborting.
   assign owner_req = owner_q ? req1 : req0;

   // Arbitration: a lone requester wins; on a tie the one that did not go
   // last wins. With only req0 high, req1 is 0 and selects requester 0.
   assign winner = (req0 && req1) ? ~last_q : req1;

   // Next-state and next-output computation. All outputs are derived here
   // for the upcoming cycle so that every port is driven from a flop.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      len_d   = len_q;
      last_d  = last_q;
      owner_d = owner_q;
      gnt0_d  = gnt0_q;
      gnt1_d  = gnt1_q;
      done0_d = 1'b0;
      done1_d = 1'b0;

      case (state_q)
         IDLE: begin
            count_d = '0;
            gnt0_d  = 1'b0;
            gnt1_d  = 1'b0;
            if (req0 || req1) begin
               state_d = RUN;
               owner_d = winner;
               last_d  = winner;
               len_d   = winner ? len1 : len0;
               gnt0_d  = ~winner;
               gnt1_d  = winner;
            end
         end

         RUN: begin
            // Abort takes priority over reaching the end of the interval.
            if (!owner_req) begin
               state_d = IDLE;
               count_d = '0;
               gnt0_d  = 1'b0;
               gnt1_d  = 1'b0;
            end else if (count_q == len_q) begin
               state_d = DONE;
               done0_d = ~owner_q;
               done1_d = owner_q;
            end else begin
               count_d = count_q + 1'b1;
            end
         end

         DONE: begin
            state_d = IDLE;
            count_d = '0;
            gnt0_d  = 1'b0;
            gnt1_d  = 1'b0;
         end

         default: begin
            state_d = IDLE;
            count_d = '0;
            gnt0_d  = 1'b0;
            gnt1_d  = 1'b0;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   // State and output registers. Reset leaves last pointing at requester 1
   // so that requester 0 wins the first tie.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         count_q <= '0;
         len_q   <= '0;
         last_q  <= 1'b1;
         owner_q <= 1'b0;
         gnt0_q  <= 1'b0;
         gnt1_q  <= 1'b0;
         done0_q <= 1'b0;
         done1_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         len_q   <= len_d;
         last_q  <= last_d;
         owner_q <= owner_d;
         gnt0_q  <= gnt0_d;
         gnt1_q  <= gnt1_d;
         done0_q <= done0_d;
         done1_q <= done1_d;
         busy_q  <= busy_d;
      end
   end

   assign gnt0  = gnt0_q;
   assign gnt1  = gnt1_q;
   assign done0 = done0_q;
   assign done1 = done1_q;
   assign count = count_q;
   assign busy  = busy_q;

endmodule

// File: tb/tb_interval_timer_arbiter.sv
// tb_interval_timer_arbiter
//
// Scoreboard bench for interval_timer_arbiter. The driver applies inputs on
// the falling edge, advances a transaction-level reference model (owner,
// cycles elapsed since grant, latched length) and queues the outputs the DUT
// must show in the following cycle. An independent monitor pops one entry
// per cycle just after each rising edge and compares it with the DUT.

module tb_interval_timer_arbiter;

   logic       clk;
   logic       reset;
   logic       req0, req1;
   logic [7:0] len0, len1;
   logic       gnt0, gnt1, done0, done1, busy;
   logic [7:0] count;

   typedef struct packed {
      logic       g0;
      logic       g1;
      logic       d0;
      logic       d1;
      logic [7:0] cnt;
      logic       bsy;
   } exp_t;

   exp_t exp_q[$];

   int vectors    = 0;
   int miscompares = 0;
   bit stop_mon   = 0;

   // Reference model: owner is -1 when free; elapsed counts cycles since
   // the grant, and elapsed == len+1 marks the completion cycle.
   int m_owner   = -1;
   int m_last    = 1;
   int m_len     = 0;
   int m_elapsed = 0;
   exp_t m_out;

   // Requester behaviour flags used by the drive loops.
   bit want0 = 0, want1 = 0;

   interval_timer_arbiter #(.WIDTH(8)) dut (
      .clk   (clk),
      .reset (reset),
      .req0  (req0),
      .len0  (len0),
      .req1  (req1),
      .len1  (len1),
      .gnt0  (gnt0),
      .gnt1  (gnt1),
      .done0 (done0),
      .done1 (done1),
      .count (count),
      .busy  (busy)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   // Advance the model by one clock edge with the given inputs and build
   // the outputs expected for the cycle after that edge.
   task automatic model_step(input bit rst, input bit r0, input bit r1,
                             input logic [7:0] l0, input logic [7:0] l1);
      int w;
      bit oreq;
      if (rst) begin
         m_owner = -1;
         m_last  = 1;
         m_len   = 0;
      end else if (m_owner < 0) begin
         if (r0 || r1) begin
            if (r0 && r1) w = (m_last == 0) ? 1 : 0;
            else          w = r0 ? 0 : 1;
            m_owner   = w;
            m_last    = w;
            m_len     = (w == 1) ? int'(l1) : int'(l0);
            m_elapsed = 0;
         end
      end else if (m_elapsed > m_len) begin
         m_owner = -1;
      end else begin
         oreq = (m_owner == 1) ? r1 : r0;
         if (!oreq) m_owner = -1;
         else       m_elapsed = m_elapsed + 1;
      end

      m_out = '0;
      if (m_owner >= 0) begin
         m_out.bsy = 1'b1;
         if (m_owner == 0) m_out.g0 = 1'b1;
         else              m_out.g1 = 1'b1;
         if (m_elapsed > m_len) begin
            m_out.cnt = 8'(m_len);
            if (m_owner == 0) m_out.d0 = 1'b1;
            else              m_out.d1 = 1'b1;
         end else begin
            m_out.cnt = 8'(m_elapsed);
         end
      end
   endtask

   // Drive one cycle of inputs and queue the expected response.
   task automatic apply_stimulus(input bit rst, input bit r0, input bit r1,
                                 input logic [7:0] l0, input logic [7:0] l1);
      @(negedge clk);
      reset = rst;
      req0  = r0;
      req1  = r1;
      len0  = l0;
      len1  = l1;
      model_step(rst, r0, r1, l0, l1);
      exp_q.push_back(m_out);
   endtask

   // Requesters that hold req until done, drop it on the edge ending the
   // done cycle, and optionally re-request one cycle later.
   task automatic drive_requesters(input int cycles, input bit keep0, input bit keep1,
                                   input logic [7:0] l0, input logic [7:0] l1);
      for (int i = 0; i < cycles; i++) begin
         apply_stimulus(1'b0, want0, want1, l0, l1);
         if (m_out.d0)           want0 = 0;
         else if (!want0 && keep0) want0 = 1;
         if (m_out.d1)           want1 = 0;
         else if (!want1 && keep1) want1 = 1;
      end
   endtask

   task automatic idle_cycles(input int n);
      want0 = 0;
      want1 = 0;
      for (int i = 0; i < n; i++) apply_stimulus(1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
   endtask

   // Compare the DUT against one queued expectation.
   task automatic check_output(input exp_t e);
      exp_t a;
      a = '{g0: gnt0, g1: gnt1, d0: done0, d1: done1, cnt: count, bsy: busy};
      vectors++;
      if (a !== e) begin
         miscompares++;
         $display("[TB] FAIL cycle_outputs t=%0t actual gnt=%b%b done=%b%b count=%0d busy=%b required gnt=%b%b done=%b%b count=%0d busy=%b",
                  $time, a.g1, a.g0, a.d1, a.d0, a.cnt, a.bsy,
                  e.g1, e.g0, e.d1, e.d0, e.cnt, e.bsy);
      end
   endtask

   // Monitor: one expectation per cycle, sampled away from the clock edge.
   initial begin
      exp_t e;
      while (!stop_mon) begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_output(e);
         end
      end
   end

   initial begin
      logic [7:0] rl0, rl1;
      bit rrst;
      reset = 1'b1;
      req0  = 1'b0;
      req1  = 1'b0;
      len0  = 8'd0;
      len1  = 8'd0;

      // Reset state.
      apply_stimulus(1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
      apply_stimulus(1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
      idle_cycles(2);

      // Single request, len 3.
      want0 = 1;
      drive_requesters(8, 1'b0, 1'b0, 8'd3, 8'd0);
      idle_cycles(2);

      // Both held, len 2: alternating grants with one IDLE between.
      want0 = 1;
      want1 = 1;
      drive_requesters(25, 1'b1, 1'b1, 8'd2, 8'd2);
      idle_cycles(3);

      // len 0 on requester 0, then len 255 on requester 1.
      want0 = 1;
      drive_requesters(5, 1'b0, 1'b0, 8'd0, 8'd0);
      idle_cycles(2);
      want1 = 1;
      drive_requesters(262, 1'b0, 1'b0, 8'd0, 8'd255);
      idle_cycles(2);

      // Abort of requester 0 at count 2 with req1 pending.
      apply_stimulus(1'b0, 1'b1, 1'b1, 8'd5, 8'd3);
      apply_stimulus(1'b0, 1'b1, 1'b1, 8'd9, 8'd3);
      apply_stimulus(1'b0, 1'b1, 1'b1, 8'd9, 8'd3);
      apply_stimulus(1'b0, 1'b0, 1'b1, 8'd9, 8'd3);
      want0 = 0;
      want1 = 1;
      drive_requesters(10, 1'b0, 1'b0, 8'd5, 8'd3);
      idle_cycles(2);

      // Abort in the same cycle count reaches len.
      apply_stimulus(1'b0, 1'b1, 1'b0, 8'd2, 8'd0);
      apply_stimulus(1'b0, 1'b1, 1'b0, 8'd2, 8'd0);
      apply_stimulus(1'b0, 1'b1, 1'b0, 8'd2, 8'd0);
      apply_stimulus(1'b0, 1'b0, 1'b0, 8'd2, 8'd0);
      idle_cycles(2);

      // Reset mid-run at count 4, then a tie goes to requester 0.
      apply_stimulus(1'b0, 1'b0, 1'b1, 8'd0, 8'd9);
      for (int i = 0; i < 4; i++) apply_stimulus(1'b0, 1'b0, 1'b1, 8'd0, 8'd9);
      apply_stimulus(1'b1, 1'b0, 1'b1, 8'd0, 8'd9);
      want0 = 1;
      want1 = 1;
      drive_requesters(12, 1'b0, 1'b0, 8'd1, 8'd2);
      idle_cycles(2);

      // Randomized traffic: random requests, aborts, lengths and resets.
      for (int i = 0; i < 3000; i++) begin
         if (!want0 && ($urandom_range(0, 3) == 0)) want0 = 1;
         if (!want1 && ($urandom_range(0, 3) == 0)) want1 = 1;
         if (want0 && ($urandom_range(0, 39) == 0)) want0 = 0;
         if (want1 && ($urandom_range(0, 39) == 0)) want1 = 0;
         rl0  = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 40)) : 8'($urandom_range(0, 5));
         rl1  = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 40)) : 8'($urandom_range(0, 5));
         rrst = ($urandom_range(0, 299) == 0);
         apply_stimulus(rrst, want0, want1, rl0, rl1);
         if (m_out.d0) want0 = 0;
         if (m_out.d1) want1 = 0;
      end
      idle_cycles(2);

      repeat (2) @(negedge clk);
      stop_mon = 1;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("[TB] FAIL scoreboard_drain actual %0d entries left required 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
